// File: rtl/sram_pkg.sv
// Shared types and helpers for the dual-port node-store RAM with a clear engine.
package sram_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StClear
   } clr_state_t;

   function automatic int unsigned read_latency(input int unsigned out_reg);
      return 1 + ((out_reg != 0) ? 1 : 0);
   endfunction

   function automatic logic in_range(input int unsigned addr, input int unsigned depth);
      return addr < depth;
   endfunction

endpackage

// File: rtl/sram_clr_fsm.sv
// Clear engine: walks a pointer over every entry after reset or on request.
module sram_clr_fsm
   import sram_pkg::*;
#(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_req,
   output logic                  busy,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr
);

   localparam logic [ADDR_WIDTH-1:0] LastPtr = ADDR_WIDTH'(DEPTH - 1);

   clr_state_t            state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StClear;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      busy     = 1'b0;
      clr_we   = 1'b0;
      clr_addr = ptr_q;
      unique case (state_q)
         StIdle: begin
            if (clr_req) begin
               state_d = StClear;
               ptr_d   = '0;
            end
         end
         StClear: begin
            busy   = 1'b1;
            clr_we = 1'b1;
            if (ptr_q == LastPtr) begin
               state_d = StIdle;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         default: begin
            state_d = StClear;
            ptr_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/sram_dp_clr.sv
// Simple dual-port RAM (A writes, B reads) with clear engine, read-valid pipeline and bypass.
module sram_dp_clr
   import sram_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH = 3,
   parameter int unsigned            DATA_WIDTH = 34,
   parameter int unsigned            DEPTH      = 8,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
   parameter int unsigned            BYPASS     = 1,
   parameter int unsigned            OUT_REG    = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_req,
   output logic                  busy,
   input  logic                  we_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [DATA_WIDTH-1:0] data_a,
   input  logic                  rd_en_b,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   output logic [DATA_WIDTH-1:0] q_b,
   output logic                  rd_valid_b
);

   localparam int unsigned Lat = read_latency(OUT_REG);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  acc_wr, acc_rd, a_ok, b_ok, collide;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data, rd_data;
   logic [DATA_WIDTH-1:0] q1_q;
   logic                  v1_q;

   sram_clr_fsm #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clr_fsm (
      .clk      (clk),
      .rst      (rst),
      .clr_req  (clr_req),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   always_comb begin
      acc_wr  = we_a && !busy;
      acc_rd  = rd_en_b && !busy;
      a_ok    = in_range(32'(addr_a), DEPTH);
      b_ok    = in_range(32'(addr_b), DEPTH);
      collide = acc_wr && a_ok && (addr_a == addr_b) && (BYPASS != 0);
      // Clear writes only occur while busy, so they never race a port-A write.
      wr_en   = clr_we || (acc_wr && a_ok);
      wr_addr = clr_we ? clr_addr : addr_a;
      wr_data = clr_we ? INIT_VALUE : data_a;
      rd_data = INIT_VALUE;
      if (b_ok) rd_data = collide ? data_a : mem[addr_b];
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q <= 1'b0;
         q1_q <= '0;
      end else begin
         v1_q <= acc_rd;
         if (acc_rd) q1_q <= rd_data;
      end
   end

   if (Lat == 2) begin : g_out_reg
      logic [DATA_WIDTH-1:0] q2_q;
      logic                  v2_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            v2_q <= 1'b0;
            q2_q <= '0;
         end else begin
            v2_q <= v1_q;
            if (v1_q) q2_q <= q1_q;
         end
      end

      assign q_b        = q2_q;
      assign rd_valid_b = v2_q;
   end else begin : g_no_out_reg
      assign q_b        = q1_q;
      assign rd_valid_b = v1_q;
   end

endmodule

// File: tb/tb_sram_dp_clr.sv
// Drives two configurations of sram_dp_clr with shared stimulus against a behavioural model.
module tb_sram_dp_clr;

   localparam logic [33:0] Init = 34'h1_0000_0001;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr_req = 1'b0;
   logic        we = 1'b0;
   logic [2:0]  addr_a = '0;
   logic [33:0] data_a = '0;
   logic        rd_en = 1'b0;
   logic [2:0]  addr_b = '0;

   logic        busy0, vld0, busy1, vld1;
   logic [33:0] q0, q1;

   int total = 0;
   int bad = 0;

   // Reference model state, index 0 = DEPTH 8/BYPASS/lat 1, index 1 = DEPTH 6/no bypass/lat 2.
   logic [33:0] mm [2][8];
   int          clr_left [2];
   logic        pv [2][2];
   logic [33:0] pd [2][2];
   logic [33:0] eq [2];

   always #5 clk = ~clk;

   sram_dp_clr #(
      .ADDR_WIDTH (3),
      .DATA_WIDTH (34),
      .DEPTH      (8),
      .INIT_VALUE (Init),
      .BYPASS     (1),
      .OUT_REG    (0)
   ) u_dut0 (
      .clk        (clk),
      .rst        (rst),
      .clr_req    (clr_req),
      .busy       (busy0),
      .we_a       (we),
      .addr_a     (addr_a),
      .data_a     (data_a),
      .rd_en_b    (rd_en),
      .addr_b     (addr_b),
      .q_b        (q0),
      .rd_valid_b (vld0)
   );

   sram_dp_clr #(
      .ADDR_WIDTH (3),
      .DATA_WIDTH (34),
      .DEPTH      (6),
      .INIT_VALUE (Init),
      .BYPASS     (0),
      .OUT_REG    (1)
   ) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .clr_req    (clr_req),
      .busy       (busy1),
      .we_a       (we),
      .addr_a     (addr_a),
      .data_a     (data_a),
      .rd_en_b    (rd_en),
      .addr_b     (addr_b),
      .q_b        (q1),
      .rd_valid_b (vld1)
   );

   task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input int k);
      int          d;
      int          lat;
      bit          byp;
      logic [33:0] rv;
      d   = (k == 0) ? 8 : 6;
      lat = (k == 0) ? 1 : 2;
      byp = (k == 0);
      if (rst) begin
         clr_left[k] = d;
         pv[k][0] = 1'b0; pv[k][1] = 1'b0;
         pd[k][0] = '0;   pd[k][1] = '0;
         eq[k] = '0;
         return;
      end
      pv[k][0] = pv[k][1];
      pd[k][0] = pd[k][1];
      pv[k][1] = 1'b0;
      if (clr_left[k] > 0) begin
         mm[k][d - clr_left[k]] = Init;
         clr_left[k]--;
      end else begin
         if (rd_en) begin
            if (int'(addr_b) >= d) rv = Init;
            else if (we && addr_a == addr_b && byp) rv = data_a;
            else rv = mm[k][addr_b];
            pv[k][lat-1] = 1'b1;
            pd[k][lat-1] = rv;
         end
         if (we && int'(addr_a) < d) mm[k][addr_a] = data_a;
         if (clr_req) clr_left[k] = d;
      end
      if (pv[k][0]) eq[k] = pd[k][0];
   endtask

   task automatic tick();
      model_edge(0);
      model_edge(1);
      @(posedge clk);
      #1;
      chk("busy0", 34'(busy0), 34'(clr_left[0] > 0));
      chk("valid0", 34'(vld0), 34'(pv[0][0]));
      chk("q0", q0, eq[0]);
      chk("busy1", 34'(busy1), 34'(clr_left[1] > 0));
      chk("valid1", 34'(vld1), 34'(pv[1][0]));
      chk("q1", q1, eq[1]);
   endtask

   task automatic drive(input logic r, input logic c, input logic w, input logic [2:0] aa,
                        input logic [33:0] da, input logic rd, input logic [2:0] ab);
      rst = r; clr_req = c; we = w; addr_a = aa; data_a = da; rd_en = rd; addr_b = ab;
      tick();
   endtask

   function automatic logic [33:0] rnd34();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[33:0];
   endfunction

   initial begin
      // Reset held three cycles, then the full clear.
      for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, '0, 0, 0);
      for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, '0, 0, 0);
      for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, '0, 1, 3'(i));
      drive(0, 0, 0, 0, '0, 0, 0);
      drive(0, 0, 0, 0, '0, 0, 0);

      // Write then read back.
      drive(0, 0, 1, 3, 34'h2_AAAA_5555, 0, 0);
      drive(0, 0, 0, 0, '0, 1, 3);
      drive(0, 0, 0, 0, '0, 0, 0);
      drive(0, 0, 0, 0, '0, 0, 0);

      // Same-address collision, then a follow-up read.
      drive(0, 0, 1, 5, 34'h0_0000_00FF, 0, 0);
      drive(0, 0, 1, 5, 34'h3_1234_5678, 1, 5);
      drive(0, 0, 0, 0, '0, 1, 5);
      drive(0, 0, 0, 0, '0, 0, 0);
      drive(0, 0, 0, 0, '0, 0, 0);

      // Fill, request a clear, and hammer the ports while busy.
      for (int i = 0; i < 8; i++) drive(0, 0, 1, 3'(i), rnd34(), 0, 0);
      drive(0, 1, 0, 0, '0, 1, 4);
      for (int i = 0; i < 8; i++)
         drive(0, (i == 3), 1, 2, rnd34(), 1, 3'($urandom_range(0, 7)));
      for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, '0, 1, 3'(i));
      drive(0, 0, 0, 0, '0, 0, 0);

      // Out-of-range write and read.
      for (int i = 0; i < 6; i++) drive(0, 0, 1, 3'(i), rnd34(), 0, 0);
      drive(0, 0, 1, 7, 34'h1_FFFF_FFFF, 0, 0);
      drive(0, 0, 0, 0, '0, 1, 7);
      for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, '0, 1, 3'(i));
      drive(0, 0, 0, 0, '0, 0, 0);

      // Reset in the middle of a requested clear.
      drive(0, 1, 0, 0, '0, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, '0, 0, 0);
      drive(1, 0, 0, 0, '0, 0, 0);
      for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, '0, 0, 0);
      for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, '0, 1, 3'(i));

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         logic r;
         r = ($urandom_range(0, 199) == 0);
         drive(r, ($urandom_range(0, 39) == 0), !r && $urandom_range(0, 1) == 1,
               3'($urandom_range(0, 7)), rnd34(), !r && $urandom_range(0, 2) != 0,
               3'($urandom_range(0, 7)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
